// File: rtl/pkfb_mc_pkg.sv
// Shared types and helpers for the multi-channel PKfb packet FIFO.
package pkfb_mc_pkg;

  localparam int PKFB_DATA_W = 32;

  typedef struct packed {
    logic                   sof;
    logic                   eof;
    logic [PKFB_DATA_W-1:0] data;
  } pkfb_entry_t;

  typedef enum logic [0:0] {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } pkfb_chan_state_e;

  function automatic int calc_cw(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pkfb_mc_fifo_if.sv
// Fabric push / consumer read bundle of the multi-channel PKfb FIFO.
interface pkfb_mc_fifo_if
  import pkfb_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int LW    = $clog2(DEPTH) + 1,
  localparam int CW    = calc_cw(NUM_CH)
);
  logic [NUM_CH-1:0]    FB_PKfbPush;
  logic [DATA_W-1:0]    FB_PKfbData;
  logic                 FB_PKfbSOF;
  logic                 FB_PKfbEOF;
  logic [NUM_CH-1:0]    Ovf_Clr;
  logic [NUM_CH-1:0]    FB_PKfbOverflow;
  logic                 Rd_Req;
  logic [CW-1:0]        Rd_Ch;
  logic                 Rd_Valid;
  logic [DATA_W-1:0]    Rd_Data;
  logic                 Rd_SOF;
  logic                 Rd_EOF;
  logic [NUM_CH-1:0]    SDMA_Req;
  logic [NUM_CH*LW-1:0] Fifo_Level;

  modport master (
    output FB_PKfbPush, FB_PKfbData, FB_PKfbSOF, FB_PKfbEOF, Ovf_Clr, Rd_Req, Rd_Ch,
    input  FB_PKfbOverflow, Rd_Valid, Rd_Data, Rd_SOF, Rd_EOF, SDMA_Req, Fifo_Level
  );

  modport slave (
    input  FB_PKfbPush, FB_PKfbData, FB_PKfbSOF, FB_PKfbEOF, Ovf_Clr, Rd_Req, Rd_Ch,
    output FB_PKfbOverflow, Rd_Valid, Rd_Data, Rd_SOF, Rd_EOF, SDMA_Req, Fifo_Level
  );
endinterface

// File: rtl/pkfb_chan_fifo.sv
// One channel: tagged word storage, pointers, level, packet count,
// ACCEPT/DROP framing FSM and sticky overflow flag.
module pkfb_chan_fifo
  import pkfb_mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              push_err,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_sof,
  input  logic              push_eof,
  input  logic              pop,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] head_data,
  output logic              head_sof,
  output logic              head_eof,
  output logic [LW-1:0]     level,
  output logic [LW-1:0]     level_next,
  output logic [LW-1:0]     pkt_cnt_next,
  output logic              overflow
);
  typedef struct packed {
    logic              sof;
    logic              eof;
    logic [DATA_W-1:0] data;
  } chan_entry_t;

  chan_entry_t      mem [DEPTH];
  chan_entry_t      head;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic [LW-1:0]    pkt_cnt_reg;
  pkfb_chan_state_e state_reg;
  pkfb_chan_state_e state_next;
  logic             ovf_reg;
  logic             ovf_next;
  logic             ovf_set;
  logic             wr_en;

  // Head is read combinationally so the top can register the selected word.
  assign head = mem[rd_ptr_reg];

  always_comb begin
    wr_en      = 1'b0;
    ovf_set    = push_err;
    state_next = state_reg;
    if (push && (state_reg == ACCEPT || push_sof)) begin
      if (level_reg != LW'(DEPTH) || pop) begin
        wr_en      = 1'b1;
        state_next = ACCEPT;
      end else begin
        ovf_set    = 1'b1;
        state_next = DROP;
      end
    end
    level_next   = level_reg + LW'(wr_en) - LW'(pop);
    pkt_cnt_next = pkt_cnt_reg + LW'(wr_en && push_eof) - LW'(pop && head.eof);
    // A new overflow event wins over a same-cycle clear.
    ovf_next     = ovf_set | (ovf_reg & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      pkt_cnt_reg <= '0;
      state_reg   <= ACCEPT;
      ovf_reg     <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg   <= level_next;
      pkt_cnt_reg <= pkt_cnt_next;
      state_reg   <= state_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= '{sof: push_sof, eof: push_eof, data: push_data};
  end

  assign head_data = head.data;
  assign head_sof  = head.sof;
  assign head_eof  = head.eof;
  assign level     = level_reg;
  assign overflow  = ovf_reg;

endmodule

// File: rtl/pkfb_mc_fifo.sv
// Multi-channel PKfb packet FIFO: push decode, per-channel FIFOs,
// registered read port and per-channel SDMA service requests.
module pkfb_mc_fifo
  import pkfb_mc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 16,
  parameter int REQ_THRESH = 8,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic           Sys_PKfb_Clk,
  input  logic           Sys_PKfb_Rst_n,
  pkfb_mc_fifo_if.slave  bus
);
  logic                push_onehot;
  logic [NUM_CH-1:0]   push_ok;
  logic [NUM_CH-1:0]   push_err;
  logic [NUM_CH-1:0]   pop_vec;
  logic [NUM_CH-1:0]   head_sof;
  logic [NUM_CH-1:0]   head_eof;
  logic [NUM_CH-1:0]   ovf_vec;
  logic [DATA_W-1:0]   head_data    [NUM_CH];
  logic [LW-1:0]       level        [NUM_CH];
  logic [LW-1:0]       level_next   [NUM_CH];
  logic [LW-1:0]       pkt_cnt_next [NUM_CH];
  logic                rd_hit;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_sof;
  logic                sel_eof;
  logic                rd_valid_reg;
  logic [DATA_W-1:0]   rd_data_reg;
  logic                rd_sof_reg;
  logic                rd_eof_reg;
  logic [NUM_CH-1:0]   sdma_req_reg;

  // A multi-hot strobe writes nowhere and flags every addressed channel.
  assign push_onehot = $onehot(bus.FB_PKfbPush);
  assign push_ok     = bus.FB_PKfbPush & {NUM_CH{push_onehot}};
  assign push_err    = bus.FB_PKfbPush & {NUM_CH{~push_onehot}};

  always_comb begin
    pop_vec  = '0;
    rd_hit   = 1'b0;
    sel_data = '0;
    sel_sof  = 1'b0;
    sel_eof  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.Rd_Req && int'(bus.Rd_Ch) == c && level[c] != '0) begin
        pop_vec[c] = 1'b1;
        rd_hit     = 1'b1;
        sel_data   = head_data[c];
        sel_sof    = head_sof[c];
        sel_eof    = head_eof[c];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pkfb_chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_chan (
      .clk          (Sys_PKfb_Clk),
      .rst_n        (Sys_PKfb_Rst_n),
      .push         (push_ok[gi]),
      .push_err     (push_err[gi]),
      .push_data    (bus.FB_PKfbData),
      .push_sof     (bus.FB_PKfbSOF),
      .push_eof     (bus.FB_PKfbEOF),
      .pop          (pop_vec[gi]),
      .ovf_clr      (bus.Ovf_Clr[gi]),
      .head_data    (head_data[gi]),
      .head_sof     (head_sof[gi]),
      .head_eof     (head_eof[gi]),
      .level        (level[gi]),
      .level_next   (level_next[gi]),
      .pkt_cnt_next (pkt_cnt_next[gi]),
      .overflow     (ovf_vec[gi])
    );
    assign bus.Fifo_Level[gi*LW +: LW] = level[gi];
  end

  always_ff @(posedge Sys_PKfb_Clk) begin
    if (!Sys_PKfb_Rst_n) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      rd_sof_reg   <= 1'b0;
      rd_eof_reg   <= 1'b0;
      sdma_req_reg <= '0;
    end else begin
      rd_valid_reg <= rd_hit;
      if (rd_hit) begin
        rd_data_reg <= sel_data;
        rd_sof_reg  <= sel_sof;
        rd_eof_reg  <= sel_eof;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        sdma_req_reg[c] <= (pkt_cnt_next[c] != '0) || (level_next[c] >= LW'(REQ_THRESH));
      end
    end
  end

  assign bus.FB_PKfbOverflow = ovf_vec;
  assign bus.Rd_Valid        = rd_valid_reg;
  assign bus.Rd_Data         = rd_data_reg;
  assign bus.Rd_SOF          = rd_sof_reg;
  assign bus.Rd_EOF          = rd_eof_reg;
  assign bus.SDMA_Req        = sdma_req_reg;

endmodule

// File: tb/tb_pkfb_mc_fifo.sv
// Self-checking bench for pkfb_mc_fifo: directed scenarios plus randomized
// traffic checked against a queue-based packet model.
module tb_pkfb_mc_fifo;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int THR = 8;
  localparam int LW  = 5;

  typedef struct packed {
    logic          sof;
    logic          eof;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pkfb_mc_fifo_if #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEP)) bus ();

  pkfb_mc_fifo #(
    .NUM_CH     (NCH),
    .DATA_W     (DW),
    .DEPTH      (DEP),
    .REQ_THRESH (THR)
  ) dut (
    .Sys_PKfb_Clk   (clk),
    .Sys_PKfb_Rst_n (rst_n),
    .bus            (bus)
  );

  ent_t       mq [NCH][$];
  bit         m_drop [NCH];
  logic [3:0] m_ovf;
  bit         e_valid;
  ent_t       e_rd;
  int         n_cmp = 0;
  int         n_err = 0;

  function automatic logic exp_sdma(input int c);
    bit has_eof = 0;
    for (int i = 0; i < mq[c].size(); i++) if (mq[c][i].eof) has_eof = 1;
    return has_eof || (mq[c].size() >= THR);
  endfunction

  function automatic logic [LW-1:0] got_level(input int c);
    return bus.Fifo_Level[c*LW +: LW];
  endfunction

  task automatic idle();
    bus.FB_PKfbPush = '0;
    bus.FB_PKfbData = '0;
    bus.FB_PKfbSOF  = 1'b0;
    bus.FB_PKfbEOF  = 1'b0;
    bus.Ovf_Clr     = '0;
    bus.Rd_Req      = 1'b0;
    bus.Rd_Ch       = '0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_drop[c] = 0;
    end
    m_ovf   = '0;
    e_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus; model applies the packet rules to pre-cycle state.
  task automatic cycle(input logic [3:0] push, input logic [DW-1:0] d, input logic sof,
                       input logic eof, input logic [3:0] clr, input logic rreq,
                       input logic [1:0] rch);
    int         pre [NCH];
    logic [3:0] set;
    for (int c = 0; c < NCH; c++) pre[c] = mq[c].size();
    e_valid = 0;
    if (rreq && pre[rch] > 0) begin
      e_rd    = mq[rch].pop_front();
      e_valid = 1;
    end
    set = '0;
    if ($countones(push) > 1) begin
      set = push;
    end else if (push != '0) begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c] && (!m_drop[c] || sof)) begin
          if (pre[c] < DEP || (rreq && rch == c && pre[c] > 0)) begin
            mq[c].push_back('{sof: sof, eof: eof, data: d});
            m_drop[c] = 0;
          end else begin
            m_drop[c] = 1;
            set[c]    = 1'b1;
          end
        end
      end
    end
    m_ovf = set | (m_ovf & ~clr);
    bus.FB_PKfbPush = push;
    bus.FB_PKfbData = d;
    bus.FB_PKfbSOF  = sof;
    bus.FB_PKfbEOF  = eof;
    bus.Ovf_Clr     = clr;
    bus.Rd_Req      = rreq;
    bus.Rd_Ch       = rch;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.Fifo_Level !== '0) begin n_err++; $display("FAIL reset_level: got %0h want 0", bus.Fifo_Level); end
    n_cmp++; if (bus.FB_PKfbOverflow !== '0) begin n_err++; $display("FAIL reset_ovf: got %0h want 0", bus.FB_PKfbOverflow); end
    n_cmp++; if (bus.SDMA_Req !== '0) begin n_err++; $display("FAIL reset_sdma: got %0h want 0", bus.SDMA_Req); end
    n_cmp++; if (bus.Rd_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", bus.Rd_Valid); end
    n_cmp++; if (bus.Rd_Data !== '0) begin n_err++; $display("FAIL reset_data: got %0h want 0", bus.Rd_Data); end
    $display("test_reset done");
  endtask

  task automatic test_packet();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0010, $urandom, i == 0, i == 2, 4'b0, 1'b0, 2'd0);
      if (i == 1) begin
        n_cmp++; if (bus.SDMA_Req[1] !== 1'b0) begin n_err++; $display("FAIL pkt_sdma_early: got %0b want 0", bus.SDMA_Req[1]); end
      end
    end
    n_cmp++; if (got_level(1) !== 5'd3) begin n_err++; $display("FAIL pkt_level: got %0d want 3", got_level(1)); end
    n_cmp++; if (bus.SDMA_Req[1] !== 1'b1) begin n_err++; $display("FAIL pkt_sdma: got %0b want 1", bus.SDMA_Req[1]); end
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0, '0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd1);
      n_cmp++; if (bus.Rd_Valid !== 1'b1) begin n_err++; $display("FAIL pkt_valid%0d: got %0b want 1", i, bus.Rd_Valid); end
      n_cmp++; if ({bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data} !== e_rd) begin n_err++; $display("FAIL pkt_word%0d: got %0h want %0h", i, {bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data}, e_rd); end
      n_cmp++; if ({bus.Rd_SOF, bus.Rd_EOF} !== {1'(i == 0), 1'(i == 2)}) begin n_err++; $display("FAIL pkt_tags%0d: got %0b%0b want %0b%0b", i, bus.Rd_SOF, bus.Rd_EOF, i == 0, i == 2); end
    end
    n_cmp++; if (got_level(1) !== 5'd0) begin n_err++; $display("FAIL pkt_level_end: got %0d want 0", got_level(1)); end
    n_cmp++; if (bus.SDMA_Req[1] !== 1'b0) begin n_err++; $display("FAIL pkt_sdma_end: got %0b want 0", bus.SDMA_Req[1]); end
    $display("test_packet done");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEP; i++) cycle(4'b0001, $urandom, i == 0, 1'b0, 4'b0, 1'b0, 2'd0);
    n_cmp++; if (got_level(0) !== 5'd16) begin n_err++; $display("FAIL ovf_fill: got %0d want 16", got_level(0)); end
    n_cmp++; if (bus.FB_PKfbOverflow[0] !== 1'b0) begin n_err++; $display("FAIL ovf_fill_flag: got %0b want 0", bus.FB_PKfbOverflow[0]); end
    cycle(4'b0001, $urandom, 1'b0, 1'b0, 4'b0, 1'b0, 2'd0);
    n_cmp++; if (bus.FB_PKfbOverflow[0] !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %0b want 1", bus.FB_PKfbOverflow[0]); end
    n_cmp++; if (got_level(0) !== 5'd16) begin n_err++; $display("FAIL ovf_level17: got %0d want 16", got_level(0)); end
    cycle(4'b0001, $urandom, 1'b0, 1'b0, 4'b0, 1'b0, 2'd0);
    cycle(4'b0001, $urandom, 1'b0, 1'b0, 4'b0, 1'b0, 2'd0);
    n_cmp++; if (got_level(0) !== 5'd16) begin n_err++; $display("FAIL ovf_drop_mode: got %0d want 16", got_level(0)); end
    cycle(4'b0, '0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd0);
    n_cmp++; if (got_level(0) !== 5'd15) begin n_err++; $display("FAIL ovf_pop: got %0d want 15", got_level(0)); end
    cycle(4'b0001, $urandom, 1'b1, 1'b0, 4'b0, 1'b0, 2'd0);
    n_cmp++; if (got_level(0) !== 5'd16) begin n_err++; $display("FAIL ovf_sof_resume: got %0d want 16", got_level(0)); end
    $display("test_overflow done");
  endtask

  task automatic test_ovf_clr();
    cycle(4'b0, '0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0);
    n_cmp++; if (bus.FB_PKfbOverflow[0] !== 1'b0) begin n_err++; $display("FAIL clr_alone1: got %0b want 0", bus.FB_PKfbOverflow[0]); end
    cycle(4'b0001, $urandom, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0);
    n_cmp++; if (bus.FB_PKfbOverflow[0] !== 1'b1) begin n_err++; $display("FAIL clr_vs_set: got %0b want 1", bus.FB_PKfbOverflow[0]); end
    cycle(4'b0, '0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0);
    n_cmp++; if (bus.FB_PKfbOverflow[0] !== 1'b0) begin n_err++; $display("FAIL clr_alone2: got %0b want 0", bus.FB_PKfbOverflow[0]); end
    $display("test_ovf_clr done");
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < DEP; i++) cycle(4'b0100, $urandom, i == 0, 1'b0, 4'b0, 1'b0, 2'd0);
    cycle(4'b0100, $urandom, 1'b0, 1'b0, 4'b0, 1'b1, 2'd2);
    n_cmp++; if (got_level(2) !== 5'd16) begin n_err++; $display("FAIL fullpp_level: got %0d want 16", got_level(2)); end
    n_cmp++; if (bus.FB_PKfbOverflow[2] !== 1'b0) begin n_err++; $display("FAIL fullpp_ovf: got %0b want 0", bus.FB_PKfbOverflow[2]); end
    n_cmp++; if ({bus.Rd_Valid, bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data} !== {1'b1, e_rd}) begin n_err++; $display("FAIL fullpp_word: got %0h want %0h", {bus.Rd_Valid, bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data}, {1'b1, e_rd}); end
    $display("test_full_pushpop done");
  endtask

  task automatic test_multihot();
    cycle(4'b0011, $urandom, 1'b1, 1'b1, 4'b0, 1'b0, 2'd0);
    n_cmp++; if (bus.FB_PKfbOverflow !== 4'b0011) begin n_err++; $display("FAIL mh_ovf: got %0b want 0011", bus.FB_PKfbOverflow); end
    n_cmp++; if (got_level(0) !== 5'd16 || got_level(1) !== 5'd0) begin n_err++; $display("FAIL mh_levels: got %0d/%0d want 16/0", got_level(0), got_level(1)); end
    cycle(4'b0, '0, 1'b0, 1'b0, 4'b0, 1'b1, 2'd3);
    n_cmp++; if (bus.Rd_Valid !== 1'b0) begin n_err++; $display("FAIL empty_rd: got %0b want 0", bus.Rd_Valid); end
    $display("test_multihot done");
  endtask

  task automatic test_thresh_reset();
    cycle(4'b0, '0, 1'b0, 1'b0, 4'b1111, 1'b0, 2'd0);
    for (int i = 0; i < THR; i++) begin
      cycle(4'b1000, $urandom, i == 0, 1'b0, 4'b0, 1'b0, 2'd0);
      if (i == THR - 2) begin
        n_cmp++; if (bus.SDMA_Req[3] !== 1'b0) begin n_err++; $display("FAIL thr_below: got %0b want 0", bus.SDMA_Req[3]); end
      end
    end
    n_cmp++; if (bus.SDMA_Req[3] !== 1'b1) begin n_err++; $display("FAIL thr_at: got %0b want 1", bus.SDMA_Req[3]); end
    do_reset();
    n_cmp++; if ({bus.Fifo_Level, bus.FB_PKfbOverflow, bus.SDMA_Req, bus.Rd_Valid, bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data} !== '0) begin
      n_err++; $display("FAIL midreset_outs: lvl %0h ovf %0h sdma %0h vld %0b want all 0", bus.Fifo_Level, bus.FB_PKfbOverflow, bus.SDMA_Req, bus.Rd_Valid);
    end
    cycle(4'b0001, $urandom, 1'b0, 1'b0, 4'b0, 1'b0, 2'd0);
    n_cmp++; if (got_level(0) !== 5'd1) begin n_err++; $display("FAIL midreset_accept: got %0d want 1", got_level(0)); end
    $display("test_thresh_reset done");
  endtask

  task automatic test_random();
    logic [3:0] push;
    logic [3:0] clr;
    int         r;
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) push = 4'b0001 << $urandom_range(0, 3);
      else if (r == 6) begin
        push = 4'($urandom);
        while ($countones(push) < 2) push = 4'($urandom);
      end else push = '0;
      clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      cycle(push, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, clr,
            $urandom_range(0, 9) < 4, 2'($urandom));
      n_cmp++; if (bus.Rd_Valid !== e_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got %0b want %0b", n, bus.Rd_Valid, e_valid); end
      if (e_valid) begin
        n_cmp++; if ({bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data} !== e_rd) begin n_err++; $display("FAIL rnd_word@%0d: got %0h want %0h", n, {bus.Rd_SOF, bus.Rd_EOF, bus.Rd_Data}, e_rd); end
      end
      n_cmp++; if (bus.FB_PKfbOverflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %0b want %0b", n, bus.FB_PKfbOverflow, m_ovf); end
      for (int c = 0; c < NCH; c++) begin
        n_cmp++; if (got_level(c) !== LW'(mq[c].size())) begin n_err++; $display("FAIL rnd_level%0d@%0d: got %0d want %0d", c, n, got_level(c), mq[c].size()); end
        n_cmp++; if (bus.SDMA_Req[c] !== exp_sdma(c)) begin n_err++; $display("FAIL rnd_sdma%0d@%0d: got %0b want %0b", c, n, bus.SDMA_Req[c], exp_sdma(c)); end
      end
    end
    $display("test_random done");
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_packet();
    test_overflow();
    test_ovf_clr();
    test_full_pushpop();
    test_multihot();
    test_thresh_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
